// File: rtl/regfile_wb_unit_pkg.sv
// Shared types and constants for the register-file write-back unit.
package regfile_pkg;

    localparam int N        = 32;
    localparam int ADDRESS  = 5;
    localparam int M        = 2 ** ADDRESS;
    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic [ADDRESS-1:0] addr;
        logic [N-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wb_unit_if.sv
// Issue, result and register-file write bus of the write-back unit.
interface regfile_wb_unit_if;
    import regfile_pkg::*;

    logic               issue_valid_i;
    logic [ADDRESS-1:0] issue_rd_addr_i;
    logic               issue_long_i;
    logic [ADDRESS-1:0] dec_rs1_addr_i;
    logic [ADDRESS-1:0] dec_rs2_addr_i;
    logic               issue_ready_o;
    logic               stall_o;
    logic               alu_valid_i;
    logic [ADDRESS-1:0] alu_rd_addr_i;
    logic [N-1:0]       alu_data_i;
    logic               alu_ready_o;
    logic               mem_valid_i;
    logic [ADDRESS-1:0] mem_rd_addr_i;
    logic [N-1:0]       mem_data_i;
    logic               mem_ready_o;
    logic [N-1:0]       rd_data_o;
    logic               rd_wr_o;
    logic [ADDRESS-1:0] rd_addr_o;

    modport master (
        output issue_valid_i, issue_rd_addr_i, issue_long_i, dec_rs1_addr_i, dec_rs2_addr_i,
        output alu_valid_i, alu_rd_addr_i, alu_data_i,
        output mem_valid_i, mem_rd_addr_i, mem_data_i,
        input  issue_ready_o, stall_o, alu_ready_o, mem_ready_o,
        input  rd_data_o, rd_wr_o, rd_addr_o
    );

    modport slave (
        input  issue_valid_i, issue_rd_addr_i, issue_long_i, dec_rs1_addr_i, dec_rs2_addr_i,
        input  alu_valid_i, alu_rd_addr_i, alu_data_i,
        input  mem_valid_i, mem_rd_addr_i, mem_data_i,
        output issue_ready_o, stall_o, alu_ready_o, mem_ready_o,
        output rd_data_o, rd_wr_o, rd_addr_o
    );

endinterface

// File: rtl/regfile_wb_unit_fifo.sv
// Synchronous FIFO holding memory results awaiting the register-file write port.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output wb_entry_t head
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    wb_entry_t   store [DEPTH];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                store[wr_ptr[AW-1:0]] <= push_entry;
                wr_ptr                <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = store[rd_ptr[AW-1:0]];

endmodule

// File: rtl/regfile_wb_unit.sv
// Register-file write-port controller: ALU/memory arbitration plus pending-write scoreboard.
// Optional stall counter output enabled by defining REGFILE_WB_STALL_CNT_EN.
module regfile_wb_unit
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    regfile_wb_unit_if.slave  bus
`ifdef REGFILE_WB_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt_o
`endif
);

    logic      fifo_full;
    logic      fifo_empty;
    logic      fifo_push;
    logic      fifo_pop;
    wb_entry_t fifo_head;
    wb_entry_t mem_entry;
    logic      alu_sel;
    logic      issue_set;
    logic [M-1:0] pend;

    assign mem_entry.addr = bus.mem_rd_addr_i;
    assign mem_entry.data = bus.mem_data_i;

    // A full FIFO blocks both sources so its head can drain ahead of the ALU.
    assign bus.mem_ready_o = rst_ni && !fifo_full;
    assign bus.alu_ready_o = rst_ni && !fifo_full;

    assign fifo_push = bus.mem_valid_i && bus.mem_ready_o
                       && (bus.mem_rd_addr_i != ADDRESS'(REG_ZERO));
    assign alu_sel   = bus.alu_valid_i && bus.alu_ready_o;
    assign fifo_pop  = rst_ni && !fifo_empty && (fifo_full || !bus.alu_valid_i);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push       (fifo_push),
        .push_entry (mem_entry),
        .pop        (fifo_pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head       (fifo_head)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            bus.rd_wr_o   <= 1'b0;
            bus.rd_addr_o <= '0;
            bus.rd_data_o <= '0;
        end else if (alu_sel) begin
            bus.rd_wr_o <= (bus.alu_rd_addr_i != ADDRESS'(REG_ZERO));
            if (bus.alu_rd_addr_i != ADDRESS'(REG_ZERO)) begin
                bus.rd_addr_o <= bus.alu_rd_addr_i;
                bus.rd_data_o <= bus.alu_data_i;
            end
        end else if (fifo_pop) begin
            bus.rd_wr_o   <= 1'b1;
            bus.rd_addr_o <= fifo_head.addr;
            bus.rd_data_o <= fifo_head.data;
        end else begin
            bus.rd_wr_o <= 1'b0;
        end
    end

    assign bus.stall_o = bus.issue_valid_i && (pend[bus.dec_rs1_addr_i]
                                               | pend[bus.dec_rs2_addr_i]
                                               | pend[bus.issue_rd_addr_i]);
    assign bus.issue_ready_o = !bus.stall_o;

    assign issue_set = bus.issue_valid_i && bus.issue_ready_o && bus.issue_long_i
                       && (bus.issue_rd_addr_i != ADDRESS'(REG_ZERO));

    // The set is scheduled after the clear so a coinciding new long issue keeps its bit.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pend <= '0;
        end else begin
            if (fifo_pop) begin
                pend[fifo_head.addr] <= 1'b0;
            end
            if (issue_set) begin
                pend[bus.issue_rd_addr_i] <= 1'b1;
            end
        end
    end

`ifdef REGFILE_WB_STALL_CNT_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stall_cnt_o <= '0;
        end else if ((bus.stall_o || (bus.alu_valid_i && !bus.alu_ready_o))
                     && (stall_cnt_o != 32'hFFFF_FFFF)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_unit.sv
// Directed self-checking bench for regfile_wb_unit.
module tb_regfile_wb_unit;
    import regfile_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   passed;

    regfile_wb_unit_if bus ();

`ifdef REGFILE_WB_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    regfile_wb_unit #(.DEPTH(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .bus         (bus.slave)
`ifdef REGFILE_WB_STALL_CNT_EN
        ,
        .stall_cnt_o (stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks = checks + 1;
        assert (observed === expected) passed = passed + 1;
        else $error("FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_write(input string tag, input logic wr,
                               input logic [4:0] addr, input logic [31:0] data);
        check_output({tag, "_wr"}, 32'(bus.rd_wr_o), 32'(wr));
        check_output({tag, "_addr"}, 32'(bus.rd_addr_o), 32'(addr));
        check_output({tag, "_data"}, bus.rd_data_o, data);
    endtask

    // Contention table: ALU held six cycles while four memory results arrive.
    logic       c_alu_v   [9] = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
    logic [4:0] c_alu_rd  [9] = '{20, 21, 22, 23, 24, 24, 0, 0, 0};
    logic       c_mem_v   [9] = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
    logic [4:0] c_mem_rd  [9] = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
    logic       c_alu_rdy [9] = '{1, 1, 1, 1, 0, 1, 1, 1, 1};
    logic       c_mem_rdy [9] = '{1, 1, 1, 1, 0, 1, 1, 1, 1};
    logic [4:0] c_wr_addr [9] = '{20, 21, 22, 23, 1, 24, 2, 3, 4};
    logic       c_wr_alu  [9] = '{1, 1, 1, 1, 0, 1, 0, 0, 0};

    initial begin
        checks = 0;
        passed = 0;
        rst_n = 1'b0;
        bus.issue_valid_i   = 1'b0;
        bus.issue_rd_addr_i = '0;
        bus.issue_long_i    = 1'b0;
        bus.dec_rs1_addr_i  = '0;
        bus.dec_rs2_addr_i  = '0;
        bus.alu_valid_i     = 1'b0;
        bus.alu_rd_addr_i   = '0;
        bus.alu_data_i      = '0;
        bus.mem_valid_i     = 1'b0;
        bus.mem_rd_addr_i   = '0;
        bus.mem_data_i      = '0;

        // Reset state
        tick();
        tick();
        check_write("reset", 1'b0, 5'd0, 32'h0);
        check_output("reset_alu_ready", 32'(bus.alu_ready_o), 32'd0);
        check_output("reset_mem_ready", 32'(bus.mem_ready_o), 32'd0);
        rst_n = 1'b1;
        #1;
        check_output("post_reset_alu_ready", 32'(bus.alu_ready_o), 32'd1);
        check_output("post_reset_mem_ready", 32'(bus.mem_ready_o), 32'd1);
        check_output("post_reset_stall", 32'(bus.stall_o), 32'd0);

        // ALU only
        bus.alu_valid_i   = 1'b1;
        bus.alu_rd_addr_i = 5'd5;
        bus.alu_data_i    = 32'hDEADBEEF;
        #1;
        check_output("alu_ready", 32'(bus.alu_ready_o), 32'd1);
        tick();
        bus.alu_valid_i = 1'b0;
        check_write("alu_write", 1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        check_write("alu_idle_hold", 1'b0, 5'd5, 32'hDEADBEEF);

        // x0 handling
        bus.alu_valid_i   = 1'b1;
        bus.alu_rd_addr_i = 5'd0;
        bus.alu_data_i    = 32'h1111;
        bus.mem_valid_i   = 1'b1;
        bus.mem_rd_addr_i = 5'd0;
        bus.mem_data_i    = 32'h2222;
        #1;
        check_output("x0_alu_ready", 32'(bus.alu_ready_o), 32'd1);
        check_output("x0_mem_ready", 32'(bus.mem_ready_o), 32'd1);
        tick();
        bus.alu_valid_i = 1'b0;
        bus.mem_valid_i = 1'b0;
        check_write("x0_no_write", 1'b0, 5'd5, 32'hDEADBEEF);
        tick();
        check_write("x0_fifo_empty", 1'b0, 5'd5, 32'hDEADBEEF);

        // Load hazard on x7
        bus.issue_valid_i   = 1'b1;
        bus.issue_long_i    = 1'b1;
        bus.issue_rd_addr_i = 5'd7;
        #1;
        check_output("load_issue_stall", 32'(bus.stall_o), 32'd0);
        check_output("load_issue_ready", 32'(bus.issue_ready_o), 32'd1);
        tick();
        bus.issue_long_i    = 1'b0;
        bus.issue_rd_addr_i = 5'd8;
        bus.dec_rs1_addr_i  = 5'd7;
        #1;
        check_output("raw_stall", 32'(bus.stall_o), 32'd1);
        check_output("raw_issue_ready", 32'(bus.issue_ready_o), 32'd0);
        tick();
        check_output("raw_stall_held", 32'(bus.stall_o), 32'd1);
        bus.mem_valid_i   = 1'b1;
        bus.mem_rd_addr_i = 5'd7;
        bus.mem_data_i    = 32'h1234;
        #1;
        check_output("load_mem_ready", 32'(bus.mem_ready_o), 32'd1);
        tick();
        bus.mem_valid_i = 1'b0;
        check_output("raw_stall_until_pop", 32'(bus.stall_o), 32'd1);
        tick();
        check_write("load_write", 1'b1, 5'd7, 32'h1234);
        check_output("raw_stall_released", 32'(bus.stall_o), 32'd0);
        bus.issue_valid_i  = 1'b0;
        bus.dec_rs1_addr_i = 5'd0;
        tick();
        check_output("load_write_once", 32'(bus.rd_wr_o), 32'd0);

        // Same-cycle set/clear on x9
        bus.mem_valid_i   = 1'b1;
        bus.mem_rd_addr_i = 5'd9;
        bus.mem_data_i    = 32'h99;
        tick();
        bus.mem_valid_i     = 1'b0;
        bus.issue_valid_i   = 1'b1;
        bus.issue_long_i    = 1'b1;
        bus.issue_rd_addr_i = 5'd9;
        #1;
        check_output("setclr_no_stall", 32'(bus.stall_o), 32'd0);
        tick();
        check_write("setclr_pop", 1'b1, 5'd9, 32'h99);
        bus.issue_long_i    = 1'b0;
        bus.issue_rd_addr_i = 5'd0;
        bus.dec_rs1_addr_i  = 5'd9;
        #1;
        check_output("setclr_set_wins", 32'(bus.stall_o), 32'd1);
        bus.issue_valid_i = 1'b0;
        bus.mem_valid_i   = 1'b1;
        bus.mem_rd_addr_i = 5'd9;
        bus.mem_data_i    = 32'h100;
        tick();
        bus.mem_valid_i = 1'b0;
        tick();
        check_write("setclr_second_pop", 1'b1, 5'd9, 32'h100);
        bus.issue_valid_i = 1'b1;
        #1;
        check_output("setclr_cleared", 32'(bus.stall_o), 32'd0);
        bus.issue_valid_i  = 1'b0;
        bus.dec_rs1_addr_i = 5'd0;

        // Contention between ALU and a filling FIFO
        for (int c = 0; c < 9; c++) begin
            bus.alu_valid_i   = c_alu_v[c];
            bus.alu_rd_addr_i = c_alu_rd[c];
            bus.alu_data_i    = 32'hA000_0000 + 32'(c_alu_rd[c]);
            bus.mem_valid_i   = c_mem_v[c];
            bus.mem_rd_addr_i = c_mem_rd[c];
            bus.mem_data_i    = 32'hB000_0000 + 32'(c_mem_rd[c]);
            #1;
            check_output($sformatf("cont_alu_ready_c%0d", c), 32'(bus.alu_ready_o), 32'(c_alu_rdy[c]));
            check_output($sformatf("cont_mem_ready_c%0d", c), 32'(bus.mem_ready_o), 32'(c_mem_rdy[c]));
            tick();
            check_write($sformatf("cont_c%0d", c), 1'b1, c_wr_addr[c],
                        (c_wr_alu[c] ? 32'hA000_0000 : 32'hB000_0000) + 32'(c_wr_addr[c]));
        end
        bus.alu_valid_i = 1'b0;
        bus.mem_valid_i = 1'b0;
        tick();
        check_output("cont_drained", 32'(bus.rd_wr_o), 32'd0);

        // Reset mid-operation with two buffered results and pend[3] set
        bus.issue_valid_i   = 1'b1;
        bus.issue_long_i    = 1'b1;
        bus.issue_rd_addr_i = 5'd3;
        bus.alu_valid_i     = 1'b1;
        bus.alu_rd_addr_i   = 5'd10;
        bus.alu_data_i      = 32'hC10;
        bus.mem_valid_i     = 1'b1;
        bus.mem_rd_addr_i   = 5'd3;
        bus.mem_data_i      = 32'hD03;
        tick();
        bus.issue_valid_i = 1'b0;
        bus.issue_long_i  = 1'b0;
        bus.alu_rd_addr_i = 5'd12;
        bus.alu_data_i    = 32'hC12;
        bus.mem_rd_addr_i = 5'd11;
        bus.mem_data_i    = 32'hD11;
        tick();
        rst_n           = 1'b0;
        bus.alu_valid_i = 1'b0;
        bus.mem_valid_i = 1'b0;
        #1;
        check_output("midrst_alu_ready", 32'(bus.alu_ready_o), 32'd0);
        check_output("midrst_mem_ready", 32'(bus.mem_ready_o), 32'd0);
        tick();
        rst_n = 1'b1;
        check_write("midrst_outputs", 1'b0, 5'd0, 32'h0);
        bus.issue_valid_i  = 1'b1;
        bus.dec_rs1_addr_i = 5'd3;
        #1;
        check_output("midrst_pend_cleared", 32'(bus.stall_o), 32'd0);
        bus.issue_valid_i  = 1'b0;
        bus.dec_rs1_addr_i = 5'd0;
        tick();
        check_write("midrst_no_stale_1", 1'b0, 5'd0, 32'h0);
        tick();
        check_write("midrst_no_stale_2", 1'b0, 5'd0, 32'h0);
        check_output("midrst_fifo_empty", 32'(bus.mem_ready_o), 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
